// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared widths, arbiter state and request record for the data-memory arbiter
package dm_pkg;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        BACKOFF = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic [AW-1:0] ptr;
        logic [DW-1:0] wdata;
    } dm_req_t;

endpackage

// File: rtl/dm_arb_if.sv
// rtl/dm_arb_if.sv - requester, response and memory-side signal bundle for dm_arb
interface dm_arb_if #(
    parameter int AW = dm_pkg::AW,
    parameter int DW = dm_pkg::DW
) ();

    logic [1:0]    req_valid;
    logic [1:0]    req_we;
    logic [AW-1:0] req_ptr0;
    logic [AW-1:0] req_ptr1;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic          lock1;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          lock_timeout;
    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // slave: the arbiter itself; master: requesters plus the memory model
    modport slave (
        input  req_valid, req_we, req_ptr0, req_ptr1, req_wdata0, req_wdata1, lock1, mem_rdata,
        output req_ready, rsp_valid, rsp_data, lock_timeout, mem_adr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_ptr0, req_ptr1, req_wdata0, req_wdata1, lock1, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, lock_timeout, mem_adr, mem_we, mem_wdata
    );

endinterface

// File: rtl/lut_m.sv
// rtl/lut_m.sv - pointer-to-address translation table (currently identity)
module lut_m #(
    parameter int AW = dm_pkg::AW
) (
    input  logic [AW-1:0] ptr,
    output logic [AW-1:0] adr
);

    logic [AW-1:0] map_rom [2**AW];

    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        assign map_rom[i] = AW'(i);
    end

    assign adr = map_rom[ptr];

endmodule

// File: rtl/dm_arb.sv
// rtl/dm_arb.sv - round-robin data-memory arbiter with requester-1 burst lock; DM_PTR_LUT_EN selects table mapping
module dm_arb
    import dm_pkg::*;
#(
    parameter int AW       = dm_pkg::AW,
    parameter int DW       = dm_pkg::DW,
    parameter int MAX_LOCK = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_arb_if.slave  bus
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t    state, state_nx;
    logic          rr_last, rr_last_nx;
    logic [CW-1:0] lock_cnt, lock_cnt_nx;
    logic          tag_vld, tag_vld_nx;
    logic          tag, tag_nx;
    logic          timeout;

    dm_req_t       req [2];
    logic [1:0]    gnt;
    logic          acc;
    logic          idx;
    logic          sel_we;
    logic [AW-1:0] sel_ptr;
    logic [DW-1:0] sel_wdata;
    logic [AW-1:0] map_adr;

    always_comb begin
        req[0] = '{valid: bus.req_valid[0], we: bus.req_we[0], ptr: bus.req_ptr0, wdata: bus.req_wdata0};
        req[1] = '{valid: bus.req_valid[1], we: bus.req_we[1], ptr: bus.req_ptr1, wdata: bus.req_wdata1};
    end

    // Grant depends only on state, valids and rr_last so ready never loops back on itself
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (req[0].valid && req[1].valid)
                        gnt = rr_last ? 2'b01 : 2'b10;
                    else
                        gnt = {req[1].valid, req[0].valid};
                end
                LOCKED:  gnt = {req[1].valid, 1'b0};
                BACKOFF: gnt = {1'b0, req[0].valid};
                default: gnt = 2'b00;
            endcase
        end
    end

    assign acc       = |gnt;
    assign idx       = gnt[1];
    assign sel_we    = idx ? req[1].we    : req[0].we;
    assign sel_ptr   = idx ? req[1].ptr   : req[0].ptr;
    assign sel_wdata = idx ? req[1].wdata : req[0].wdata;

`ifdef DM_PTR_LUT_EN
    lut_m #(.AW(AW)) u_lut (
        .ptr (sel_ptr),
        .adr (map_adr)
    );
`else
    assign map_adr = sel_ptr;
`endif

    assign bus.req_ready    = gnt;
    assign bus.mem_adr      = acc ? map_adr : '0;
    assign bus.mem_we       = acc & sel_we;
    assign bus.mem_wdata    = acc ? sel_wdata : '0;
    assign bus.lock_timeout = timeout;

    // A pending read tag only surfaces outside reset
    assign bus.rsp_valid = (rst_n && tag_vld) ? (tag ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data  = (rst_n && tag_vld) ? bus.mem_rdata : '0;

    always_comb begin
        state_nx    = state;
        rr_last_nx  = rr_last;
        lock_cnt_nx = lock_cnt;
        tag_vld_nx  = acc & ~sel_we;
        tag_nx      = idx;
        timeout     = 1'b0;

        if (acc)
            rr_last_nx = idx;

        unique case (state)
            IDLE: begin
                if (gnt[1] && bus.lock1) begin
                    state_nx    = LOCKED;
                    lock_cnt_nx = '0;
                end
            end
            LOCKED: begin
                lock_cnt_nx = lock_cnt + 1'b1;
                if (!bus.lock1)
                    state_nx = IDLE;
                else if (lock_cnt == CW'(MAX_LOCK - 1))
                    state_nx = BACKOFF;
            end
            BACKOFF: begin
                timeout  = rst_n;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            lock_cnt <= '0;
            tag_vld  <= 1'b0;
            tag      <= 1'b0;
        end else begin
            state    <= state_nx;
            rr_last  <= rr_last_nx;
            lock_cnt <= lock_cnt_nx;
            tag_vld  <= tag_vld_nx;
            tag      <= tag_nx;
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// tb/tb_dm_arb.sv - scoreboard bench for dm_arb with a cycle-level reference model
module tb_dm_arb;

    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dm_arb_if #(.AW(8), .DW(8)) bus ();

    dm_arb #(.AW(8), .DW(8), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Synchronous-read memory attached to the arbiter's memory port
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_adr];
    end

    typedef struct {
        logic [1:0] ready;
        logic [7:0] adr;
        logic       we;
        logic [7:0] wdata;
        logic       to;
        logic [1:0] rspv;
    } cyc_t;

    typedef struct {
        logic       idx;
        logic [7:0] data;
    } rsp_t;

    cyc_t exp_cyc[$];
    rsp_t exp_rsp[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state: who won last, how long requester 1 has held the lock
    logic [7:0] ref_mem [256];
    int last     = 1;
    bit locked   = 0;
    int held     = 0;
    bit backoff  = 0;
    bit pend     = 0;
    int pend_idx = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rstn, input logic [1:0] v, input logic [1:0] we,
                        input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] w0, input logic [7:0] w1, input logic lk);
        cyc_t       c;
        int         g;
        logic [7:0] p [2];
        logic [7:0] w [2];
        @(posedge clk);
        #1;
        rst_n          = rstn;
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_ptr0   = p0;
        bus.req_ptr1   = p1;
        bus.req_wdata0 = w0;
        bus.req_wdata1 = w1;
        bus.lock1      = lk;
        p[0] = p0; p[1] = p1; w[0] = w0; w[1] = w1;
        c = '{ready: 2'b00, adr: 8'h00, we: 1'b0, wdata: 8'h00, to: 1'b0, rspv: 2'b00};
        g = -1;
        if (!rstn) begin
            if (pend) void'(exp_rsp.pop_back());
            pend = 0; last = 1; locked = 0; held = 0; backoff = 0;
        end else begin
            c.rspv = pend ? (pend_idx == 1 ? 2'b10 : 2'b01) : 2'b00;
            if (backoff) begin
                if (v[0]) g = 0;
                c.to = 1'b1;
            end else if (locked) begin
                if (v[1]) g = 1;
            end else if (v == 2'b11) begin
                g = (last == 0) ? 1 : 0;
            end else if (v[0]) begin
                g = 0;
            end else if (v[1]) begin
                g = 1;
            end
            if (g >= 0) begin
                c.ready = 2'(1 << g);
                c.adr   = p[g];
                c.we    = we[g];
                c.wdata = w[g];
                last    = g;
            end
            if (backoff) begin
                backoff = 0;
            end else if (locked) begin
                held++;
                if (!lk) locked = 0;
                else if (held == ML) begin
                    locked  = 0;
                    backoff = 1;
                end
            end else if (g == 1 && lk) begin
                locked = 1;
                held   = 0;
            end
            pend = 0;
            if (g >= 0) begin
                if (we[g]) begin
                    ref_mem[p[g]] = w[g];
                end else begin
                    exp_rsp.push_back('{idx: g[0], data: ref_mem[p[g]]});
                    pend     = 1;
                    pend_idx = g;
                end
            end
        end
        exp_cyc.push_back(c);
    endtask

    always @(negedge clk) begin : mon
        cyc_t c;
        rsp_t r;
        if (exp_cyc.size() > 0) begin
            c = exp_cyc.pop_front();
            chk("req_ready",    32'(bus.req_ready),    32'(c.ready));
            chk("mem_adr",      32'(bus.mem_adr),      32'(c.adr));
            chk("mem_we",       32'(bus.mem_we),       32'(c.we));
            chk("mem_wdata",    32'(bus.mem_wdata),    32'(c.wdata));
            chk("lock_timeout", 32'(bus.lock_timeout), 32'(c.to));
            chk("rsp_valid",    32'(bus.rsp_valid),    32'(c.rspv));
            if (bus.rsp_valid != 2'b00) begin
                if (exp_rsp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid %0b expected none at %0t", bus.rsp_valid, $time);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_idx",  32'(bus.rsp_valid), r.idx ? 32'd2 : 32'd1);
                    chk("rsp_data", 32'(bus.rsp_data),  32'(r.data));
                end
            end else begin
                chk("rsp_data_idle", 32'(bus.rsp_data), 32'd0);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_we     = 2'b00;
        bus.req_ptr0   = 8'h00;
        bus.req_ptr1   = 8'h00;
        bus.req_wdata0 = 8'h00;
        bus.req_wdata1 = 8'h00;
        bus.lock1      = 1'b0;

        step(0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        // Preload addresses 0..15 through requester 1, with fixed values at 3 and 5
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = (i == 3) ? 8'hA5 : (i == 5) ? 8'h3C : 8'($urandom);
            step(1, 2'b10, 2'b10, 0, 8'(i), 0, d, 0);
        end

        // Reset with both requesting, then the conflict read
        step(0, 2'b11, 2'b00, 3, 5, 0, 0, 0);
        step(0, 2'b11, 2'b00, 3, 5, 0, 0, 0);
        step(1, 2'b11, 2'b00, 3, 5, 0, 0, 0);
        step(1, 2'b10, 2'b00, 3, 5, 0, 0, 0);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Write then read-back of the same address
        step(1, 2'b10, 2'b10, 0, 4, 0, 8'h77, 0);
        step(1, 2'b01, 2'b00, 4, 0, 0, 0, 0);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Lock held through timeout, backoff, then a fresh conflict
        for (int i = 0; i < 8; i++) step(1, 2'b11, 2'b00, 1, 2, 0, 0, 1);
        step(1, 2'b11, 2'b00, 1, 2, 0, 0, 0);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Early release after two locked cycles
        step(1, 2'b10, 2'b00, 6, 7, 0, 0, 1);
        step(1, 2'b11, 2'b00, 6, 7, 0, 0, 1);
        step(1, 2'b11, 2'b00, 6, 7, 0, 0, 1);
        step(1, 2'b11, 2'b00, 6, 7, 0, 0, 0);
        step(1, 2'b11, 2'b00, 6, 7, 0, 0, 0);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Pointer sweep
        for (int i = 0; i < 8; i++) step(1, 2'b01, 2'b00, 8'(i), 0, 0, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(99) != 0), 2'($urandom), 2'($urandom),
                 8'($urandom_range(15)), 8'($urandom_range(15)),
                 8'($urandom), 8'($urandom), ($urandom_range(3) != 0));
        end

        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);
        chk("cyc_drained", 32'(exp_cyc.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arb.md
# dm_arb

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between the core load/store port (requester 0) and the loader/debug port (requester 1) using round-robin priority. It translates 8-bit pointers to memory addresses, returns synchronous-read data one cycle after acceptance, and lets requester 1 lock the memory for bounded multi-beat bursts.

## Interface
Parameters:
- AW, 8, memory address width
- DW, 8, data width
- MAX_LOCK, 16, maximum cycles requester 1 may hold the memory in LOCKED (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  2  per-requester request valid
- req_we  in  2  per-requester write enable (1 = write, 0 = read)
- req_ptr0 / req_ptr1  in  AW  pointer per requester
- req_wdata0 / req_wdata1  in  DW  write data per requester
- lock1  in  1  requester 1 burst lock request
- req_ready  out  2  grant; a transfer occurs when valid && ready
- rsp_valid  out  2  read response valid, one-hot per requester
- rsp_data  out  DW  read data
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly broken
- mem_adr  out  AW  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_adr

## Operation
- Grant is combinational from state, req_valid and rr_last (last granted index).
- At most one bit of req_ready is high per cycle. Ready never depends on ready.
- States:
  - IDLE:
    - Both valid: grant the index ≠ rr_last.
    - One valid: grant it.
    - Neither valid: no grant.
    - rr_last ← granted index on acceptance.
    - Requester 1 accepted with lock1=1: next state LOCKED, lock_cnt ← 0.
  - LOCKED:
    - Only requester 1 may be granted; req_ready[0]=0.
    - lock_cnt increments every LOCKED cycle, whether or not requester 1 is valid.
    - lock1 sampled 0: next state IDLE.
    - lock1=1 and lock_cnt==MAX_LOCK-1: next state BACKOFF.
  - BACKOFF (1 cycle):
    - Only requester 0 may be granted.
    - lock_timeout=1.
    - rr_last ← 0 if requester 0 is accepted.
    - Next state IDLE.
- Accepted access drives mem_adr=map(ptr), mem_wdata=wdata, and mem_we=we, all in the same cycle.
- With no acceptance: mem_adr=0, mem_wdata=0, mem_we=0.
- Accepted read: a registered tag records the requester. Next cycle, rsp_valid[tag]=1 and rsp_data=mem_rdata.
- Writes produce no response.
- rsp_data=0 whenever rsp_valid=00.
- lock1 is ignored except on requester-1 acceptance in IDLE and throughout LOCKED.

## Timing
- Reset (rst_n=0 at edge):
  - State → IDLE, rr_last → 1 (requester 0 wins first conflict), lock_cnt → 0, response tag cleared.
  - While rst_n=0: req_ready=00, mem_we=0, mem_adr=0, mem_wdata=0, rsp_valid=00, rsp_data=0, lock_timeout=0.
- Reset mid-operation: a read accepted in the cycle before reset produces no response.
- Read latency: accept in cycle N, response in N+1. Back-to-back reads give one response per cycle.
- Write: memory is updated at the edge ending the acceptance cycle. A read of the same address in the next cycle returns the new data.
- Pointer mapping is combinational and adds no latency.

## Configuration
- DM_PTR_LUT_EN defined: map(ptr) = output of an instantiated lut_m with ptr as input.
- DM_PTR_LUT_EN not defined: map(ptr) = ptr[AW-1:0] with no table logic.
- Arbitration, latency and ports are identical in both builds.

## Structure
- Shared package dm_pkg:
  - AW/DW localparams
  - typedef enum logic[1:0] arb_state_t {IDLE, LOCKED, BACKOFF}
  - typedef struct dm_req_t {valid, we, ptr, wdata}
- Sub-module: lut_m, instantiated only under DM_PTR_LUT_EN.

## Test plan
- Reset: rst_n=0 for 2 cycles with req_valid=11 → req_ready=00, mem_we=0, rsp_valid=00. First cycle after release grants requester 0.
- Conflict: mem[3]=A5, mem[5]=3C; both issue reads (ptr0=3, ptr1=5) → cycle 0 ready=01, mem_adr=3; cycle 1 rsp_valid=01, rsp_data=A5, ready=10, mem_adr=5; cycle 2 rsp_valid=10, rsp_data=3C.
- Write/read: requester 1 writes ptr=4, data=77 → mem_we=1 and mem_adr=4 that cycle, rsp_valid=00. Requester 0 then reads ptr 4 → rsp_data=77.
- Lock timeout, MAX_LOCK=4, lock1 and both valids held high:
  - Requester 1 is granted in the IDLE entry cycle, then in 4 LOCKED cycles.
  - Then a BACKOFF cycle: ready=01 and lock_timeout=1.
  - Then IDLE, where requester 1 wins the next conflict.
- Early release: lock1 drops after 2 LOCKED cycles with req0 valid → IDLE next cycle, req_ready=01, no lock_timeout.
- Pointer map: sweep ptr 0..7 in both builds → mem_adr = ptr. The current table maps identity.
